// File: rtl/note_scroller.sv
// Chart scroller: three lane shift registers advanced once per beat, with notes = lane bit 0.
// First judge_strobe comes BEAT_DIV cycles after start. pause stalls the beat divider; loads are accepted only outside PLAY.
module note_scroller #(
    parameter int LANE_LEN = 32,
    parameter int BEAT_DIV = 12_500_000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_en,
    input  logic [1:0]                      load_lane,
    input  logic [LANE_LEN-1:0]             load_data,
    input  logic                            start,
    input  logic                            pause,
    output logic [2:0]                      notes,
    output logic                            judge_strobe,
    output logic                            beat_tick,
    output logic [$clog2(LANE_LEN+1)-1:0]   position,
    output logic                            playing,
    output logic                            song_done,
    output logic [3*LANE_LEN-1:0]           lanes
);

    localparam int DIV_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int POS_W = $clog2(LANE_LEN+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q;
    logic [2:0][LANE_LEN-1:0]   lane_q, lane_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic [POS_W-1:0]           position_q, position_d;
    logic                       beat_tick_q;

    logic                       beat_end;
    logic                       last_beat;
    logic                       start_ok;
    logic                       load_ok;

    always_comb begin
        beat_end  = (state_q == PLAY) && !pause && (div_q == DIV_W'(BEAT_DIV-1));
        last_beat = beat_end && (position_q >= POS_W'(LANE_LEN-1));
        start_ok  = start && (state_q != PLAY);
        load_ok   = load_en && (state_q != PLAY) && (load_lane != 2'd3);
    end

    // Lanes: load outside PLAY, shift right on each beat end inside PLAY.
    always_comb begin
        lane_d = lane_q;
        if (load_ok) begin
            case (load_lane)
                2'd0:    lane_d[0] = load_data;
                2'd1:    lane_d[1] = load_data;
                2'd2:    lane_d[2] = load_data;
                default: lane_d = lane_q;
            endcase
        end else if (beat_end) begin
            for (int i = 0; i < 3; i++) begin
                lane_d[i] = lane_q[i] >> 1;
            end
        end
    end

    always_comb begin
        div_d      = div_q;
        position_d = position_q;
        if (start_ok) begin
            div_d      = '0;
            position_d = '0;
        end else if (state_q == PLAY && !pause) begin
            div_d = beat_end ? '0 : div_q + DIV_W'(1);
            if (beat_end && position_q != POS_W'(LANE_LEN)) begin
                position_d = position_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            div_q       <= '0;
            position_q  <= '0;
            beat_tick_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            div_q       <= div_d;
            position_q  <= position_d;
            beat_tick_q <= beat_end;
            case (state_q)
                IDLE, DONE: if (start) state_q <= PLAY;
                PLAY:       if (last_beat) state_q <= DONE;
                default:    state_q <= IDLE;
            endcase
        end
    end

    // notes stays combinational so it only moves on the edge that closes the strobe cycle.
    assign notes        = {lane_q[2][0], lane_q[1][0], lane_q[0][0]};
    assign judge_strobe = beat_end;
    assign beat_tick    = beat_tick_q;
    assign position     = position_q;
    assign playing      = (state_q == PLAY);
    assign song_done    = (state_q == DONE);
    assign lanes        = lane_q;

endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller (LANE_LEN=8, BEAT_DIV=4): load vector table plus strobe scoreboard.
module tb_note_scroller;
    localparam int LL = 8;
    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [1:0]  load_lane;
    logic [LL-1:0] load_data;
    logic        start;
    logic        pause;
    logic [2:0]  notes;
    logic        judge_strobe;
    logic        beat_tick;
    logic [3:0]  position;
    logic        playing;
    logic        song_done;
    logic [3*LL-1:0] lanes;

    always #5 clk = ~clk;

    note_scroller #(.LANE_LEN(LL), .BEAT_DIV(BD)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_lane(load_lane),
        .load_data(load_data), .start(start), .pause(pause), .notes(notes),
        .judge_strobe(judge_strobe), .beat_tick(beat_tick), .position(position),
        .playing(playing), .song_done(song_done), .lanes(lanes)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] notes;
        logic [3:0] pos;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_e;

    // Every strobe must match the next expected (cycle, notes, position) entry.
    always @(negedge clk) begin
        if (!reset && judge_strobe) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: strobe at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("strobe_cycle", cyc, mon_e.cyc);
                check("strobe_notes", {29'd0, notes}, {29'd0, mon_e.notes});
                check("strobe_pos", {28'd0, position}, {28'd0, mon_e.pos});
            end
        end
    end

    // mode 0: no pause; mode 1: 3-cycle pause in beat 1 and 1-cycle pause on strobe 2.
    task automatic push_play(input int c, input logic [7:0] l0, input logic [7:0] l1,
                             input logic [7:0] l2, input int mode);
        sb_t e;
        for (int k = 1; k <= LL; k++) begin
            if (mode == 0)   e.cyc = c + BD*k;
            else if (k == 1) e.cyc = c + BD*k + 3;
            else             e.cyc = c + BD*k + 4;
            e.notes = {l2[k-1], l1[k-1], l0[k-1]};
            e.pos   = 4'(k-1);
            sbq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    task automatic load(input logic [1:0] ln, input logic [7:0] d);
        load_en = 1'b1; load_lane = ln; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_notes"}, {29'd0, notes}, 32'd0);
        check({tag, "_lanes"}, {8'd0, lanes}, 32'd0);
        check({tag, "_pos"}, {28'd0, position}, 32'd0);
        check({tag, "_flags"}, {28'd0, playing, song_done, beat_tick, judge_strobe}, 32'd0);
    endtask

    typedef struct {
        logic        ld_en;
        logic [1:0]  lane;
        logic [7:0]  data;
        logic [23:0] exp_lanes;
        logic [2:0]  exp_notes;
    } vec_t;
    vec_t vt[6];

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within 100000 ns");
        $fatal(1);
    end

    initial begin
        int c;
        vt[0] = '{1'b1, 2'd0, 8'h05, 24'h000005, 3'b001};
        vt[1] = '{1'b1, 2'd1, 8'h02, 24'h000205, 3'b011};
        vt[2] = '{1'b1, 2'd3, 8'hFF, 24'h000205, 3'b011};
        vt[3] = '{1'b0, 2'd2, 8'hFF, 24'h000205, 3'b011};
        vt[4] = '{1'b1, 2'd1, 8'h02, 24'h000205, 3'b011};
        vt[5] = '{1'b1, 2'd2, 8'h80, 24'h800205, 3'b001};

        reset = 1'b1; load_en = 1'b0; load_lane = '0; load_data = '0; start = 1'b0; pause = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        tick();

        // Loads in IDLE, including ignored lane 3 and load_en low.
        vt[1].exp_notes = 3'b001;
        vt[2].exp_notes = 3'b001;
        vt[3].exp_notes = 3'b001;
        vt[4].exp_notes = 3'b001;
        for (int i = 0; i < 6; i++) begin
            load_en = vt[i].ld_en; load_lane = vt[i].lane; load_data = vt[i].data;
            tick();
            load_en = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_lanes", i), {8'd0, lanes}, {8'd0, vt[i].exp_lanes});
            check($sformatf("vec%0d_notes", i), {29'd0, notes}, {29'd0, vt[i].exp_notes});
            check($sformatf("vec%0d_playing", i), {31'd0, playing}, 32'd0);
        end

        // Uninterrupted song.
        c = cyc;
        start = 1'b1;
        push_play(c, 8'h05, 8'h02, 8'h80, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("play_state", {31'd0, playing}, 32'd1);
        goto(c + BD);
        @(negedge clk);
        check("tick_before_shift", {31'd0, beat_tick}, 32'd0);
        goto(c + BD + 1);
        @(negedge clk);
        check("tick_after_shift", {31'd0, beat_tick}, 32'd1);
        check("notes_beat1", {29'd0, notes}, {29'd0, 3'b010});
        goto(c + 8*BD);
        @(negedge clk);
        check("done_early", {31'd0, song_done}, 32'd0);
        goto(c + 8*BD + 1);
        @(negedge clk);
        check("done_set", {30'd0, song_done, playing}, 32'd2);
        check("done_lanes", {8'd0, lanes}, 32'd0);
        check("done_pos", {28'd0, position}, 32'd8);
        check("sb_empty_song", sbq.size(), 32'd0);

        // Pauses, plus ignored load/start while playing.
        load(2'd0, 8'h05); load(2'd1, 8'h02); load(2'd2, 8'h80);
        c = cyc;
        start = 1'b1;
        push_play(c, 8'h05, 8'h02, 8'h80, 1);
        tick();
        start = 1'b0;
        goto(c + 2);
        pause = 1'b1;
        goto(c + 4);
        @(negedge clk);
        check("pause_pos_hold", {28'd0, position}, 32'd0);
        goto(c + 5);
        pause = 1'b0;
        goto(c + 11);
        pause = 1'b1;
        @(negedge clk);
        check("pause_kills_strobe", {31'd0, judge_strobe}, 32'd0);
        goto(c + 12);
        pause = 1'b0;
        @(negedge clk);
        check("strobe_after_pause", {31'd0, judge_strobe}, 32'd1);
        goto(c + 17);
        load_en = 1'b1; load_lane = 2'd0; load_data = 8'hFF; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        @(negedge clk);
        check("play_load_ignored", {8'd0, lanes}, 32'h100000);
        check("play_start_ignored", {28'd0, position}, 32'd3);
        goto(c + 8*BD + 5);
        @(negedge clk);
        check("pause_song_done", {31'd0, song_done}, 32'd1);
        check("sb_empty_pause", sbq.size(), 32'd0);

        // Load and start together from DONE.
        c = cyc;
        load_en = 1'b1; load_lane = 2'd1; load_data = 8'hFF; start = 1'b1;
        push_play(c, 8'h00, 8'hFF, 8'h00, 0);
        tick();
        load_en = 1'b0; start = 1'b0;
        @(negedge clk);
        check("ldstart_notes", {29'd0, notes}, 32'd2);
        check("ldstart_done_low", {31'd0, song_done}, 32'd0);
        goto(c + 8*BD);
        @(negedge clk);
        check("ldstart_done_early", {31'd0, song_done}, 32'd0);
        goto(c + 8*BD + 1);
        @(negedge clk);
        check("ldstart_done", {31'd0, song_done}, 32'd1);
        check("sb_empty_ldstart", sbq.size(), 32'd0);

        // Reset in the middle of a song.
        load(2'd0, 8'h05); load(2'd1, 8'h02); load(2'd2, 8'h80);
        c = cyc;
        start = 1'b1;
        push_play(c, 8'h05, 8'h02, 8'h80, 0);
        tick();
        start = 1'b0;
        goto(c + 3*BD + 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("midreset");
        check("midreset_strobes", sbq.size(), 32'd5);
        sbq.delete();
        goto(c + 6*BD);
        @(negedge clk);
        check("midreset_stays_idle", {30'd0, playing, song_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
